// File: rtl/vga_bounce_gen_pkg.sv
// Shared types, colours and widths for the bouncing-block pixel generator.
package vga_pkg;

    localparam int POS_W  = 11;   // position arithmetic width, wide enough that nothing wraps
    localparam int ADDR_W = 10;   // pixel address width from the VGA controller
    localparam int STEP_W = 4;    // per-move step width
    localparam int CNT_W  = 16;   // bounce counter width

    typedef logic [23:0]       rgb_t;
    typedef logic [POS_W-1:0]  pos_t;

    // Direction along one axis: increasing (right/down) or decreasing (left/up).
    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    localparam rgb_t BORDER_RGB = 24'h0000FF;
    localparam rgb_t BG_RGB     = 24'hFFFFFF;
    localparam rgb_t PALETTE [4] = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFF00};

    // Block colour for a given palette index.
    function automatic rgb_t palette_rgb(input logic [1:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_bounce_gen_if.sv
// Pixel-request / pixel-data bundle between the VGA controller and the generator.
interface vga_bounce_gen_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] h_addr;
    logic [ADDR_W-1:0] v_addr;
    logic              frame_start;
    logic              mode;
    logic              pause;
    logic [STEP_W-1:0] step_x;
    logic [STEP_W-1:0] step_y;
    rgb_t              vga_data;
    logic [CNT_W-1:0]  bounce_cnt;

    // Controller side: drives addresses and control, receives pixels.
    modport master (
        output h_addr, v_addr, frame_start, mode, pause, step_x, step_y,
        input  vga_data, bounce_cnt
    );

    // Generator side.
    modport slave (
        input  h_addr, v_addr, frame_start, mode, pause, step_x, step_y,
        output vga_data, bounce_cnt
    );

endinterface

// File: rtl/vga_bounce_gen_axis.sv
// One axis of block motion: position, direction and wall-hit detection.
// A move clamps onto the wall it would reach or cross and reverses direction.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int MIN  = 40,
    parameter int MAX  = 560,
    parameter int INIT = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_en,
    input  logic [STEP_W-1:0] step,
    output pos_t              pos,
    output logic              hit
);

    localparam pos_t MIN_P  = pos_t'(MIN);
    localparam pos_t MAX_P  = pos_t'(MAX);
    localparam pos_t INIT_P = pos_t'(INIT);

    pos_t pos_reg;
    pos_t pos_next;
    dir_t dir_reg;
    dir_t dir_next;
    pos_t step_ext;
    pos_t fwd_pos;
    pos_t low_lim;

    // Next position/direction; a zero step leaves the axis completely idle.
    always_comb begin
        step_ext = pos_t'(step);
        fwd_pos  = pos_reg + step_ext;
        low_lim  = MIN_P + step_ext;
        pos_next = pos_reg;
        dir_next = dir_reg;
        hit      = 1'b0;
        if (move_en && (step != '0)) begin
            if (dir_reg == DIR_INC) begin
                if (fwd_pos >= MAX_P) begin
                    pos_next = MAX_P;
                    dir_next = DIR_DEC;
                    hit      = 1'b1;
                end else begin
                    pos_next = fwd_pos;
                end
            end else begin
                if (pos_reg <= low_lim) begin
                    pos_next = MIN_P;
                    dir_next = DIR_INC;
                    hit      = 1'b1;
                end else begin
                    pos_next = pos_reg - step_ext;
                end
            end
        end
    end

    // Position and direction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_reg <= INIT_P;
            dir_reg <= DIR_INC;
        end else begin
            pos_reg <= pos_next;
            dir_reg <= dir_next;
        end
    end

    assign pos = pos_reg;

endmodule

// File: rtl/vga_bounce_gen.sv
// Bouncing-block pixel generator: border frame, moving block, background.
// Moves are timed either by a clock divider or by frame_start; every bounce
// bumps a saturating counter and advances the block colour.
module vga_bounce_gen
    import vga_pkg::*;
#(
    parameter int H_DISP   = 640,
    parameter int V_DISP   = 480,
    parameter int W_SIDE   = 40,
    parameter int BLK_W    = 40,
    parameter int BLK_H    = 40,
    parameter int X_INIT   = 100,
    parameter int Y_INIT   = 100,
    parameter int TICK_DIV = 500000
) (
    input  logic              clk,
    input  logic              rst,
    vga_bounce_gen_if.slave   bus
);

    // Travel limits for the block's top-left corner.
    localparam int X_MIN = W_SIDE;
    localparam int X_MAX = H_DISP - W_SIDE - BLK_W;
    localparam int Y_MIN = W_SIDE;
    localparam int Y_MAX = V_DISP - W_SIDE - BLK_H;

    // Pixel-map constants in position width.
    localparam pos_t H_DISP_P  = pos_t'(H_DISP);
    localparam pos_t V_DISP_P  = pos_t'(V_DISP);
    localparam pos_t W_SIDE_P  = pos_t'(W_SIDE);
    localparam pos_t H_EDGE_P  = pos_t'(H_DISP - W_SIDE);
    localparam pos_t V_EDGE_P  = pos_t'(V_DISP - W_SIDE);
    localparam pos_t BLK_W_P   = pos_t'(BLK_W);
    localparam pos_t BLK_H_P   = pos_t'(BLK_H);

    localparam int                TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_reg;
    logic [TICK_W-1:0] tick_next;
    logic              move_en;

    pos_t              x_pos;
    pos_t              y_pos;
    logic              hit_h;
    logic              hit_v;
    logic              bounce_evt;

    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [1:0]        col_reg;
    logic [1:0]        col_next;

    pos_t              h_pos;
    pos_t              v_pos;
    pos_t              x_end;
    pos_t              y_end;
    logic              in_active;
    logic              in_border;
    logic              in_block;
    rgb_t              pix_next;
    rgb_t              vga_data_reg;

    // Move timing: divider in mode 0, frame pulse in mode 1; pause freezes both.
    // Mode 1 parks the divider at zero so a later switch back starts a full period.
    always_comb begin
        tick_next = tick_reg;
        move_en   = 1'b0;
        if (bus.mode) begin
            tick_next = '0;
            move_en   = bus.frame_start & ~bus.pause;
        end else if (!bus.pause) begin
            if (tick_reg == TICK_LAST) begin
                tick_next = '0;
                move_en   = 1'b1;
            end else begin
                tick_next = tick_reg + TICK_W'(1);
            end
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_next;
        end
    end

    bounce_axis #(
        .MIN  (X_MIN),
        .MAX  (X_MAX),
        .INIT (X_INIT)
    ) u_axis_x (
        .clk     (clk),
        .rst     (rst),
        .move_en (move_en),
        .step    (bus.step_x),
        .pos     (x_pos),
        .hit     (hit_h)
    );

    bounce_axis #(
        .MIN  (Y_MIN),
        .MAX  (Y_MAX),
        .INIT (Y_INIT)
    ) u_axis_y (
        .clk     (clk),
        .rst     (rst),
        .move_en (move_en),
        .step    (bus.step_y),
        .pos     (y_pos),
        .hit     (hit_v)
    );

    // A corner hit on both axes in the same move is a single bounce.
    assign bounce_evt = hit_h | hit_v;

    // Bounce bookkeeping: saturating count and wrapping palette index.
    always_comb begin
        cnt_next = cnt_reg;
        col_next = col_reg;
        if (bounce_evt) begin
            if (cnt_reg != {CNT_W{1'b1}}) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
            col_next = col_reg + 2'd1;
        end
    end

    // Bounce counter and colour index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            col_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            col_reg <= col_next;
        end
    end

    assign h_pos = pos_t'(bus.h_addr);
    assign v_pos = pos_t'(bus.v_addr);
    assign x_end = x_pos + BLK_W_P;
    assign y_end = y_pos + BLK_H_P;

    // Pixel classification in priority order: blanking, border, block, background.
    always_comb begin
        in_active = (h_pos < H_DISP_P) && (v_pos < V_DISP_P);
        in_border = (h_pos < W_SIDE_P) || (h_pos >= H_EDGE_P) ||
                    (v_pos < W_SIDE_P) || (v_pos >= V_EDGE_P);
        in_block  = (h_pos >= x_pos) && (h_pos < x_end) &&
                    (v_pos >= y_pos) && (v_pos < y_end);
        pix_next  = BG_RGB;
        if (!in_active) begin
            pix_next = '0;
        end else if (in_border) begin
            pix_next = BORDER_RGB;
        end else if (in_block) begin
            pix_next = palette_rgb(col_reg);
        end
    end

    // Output pixel register; uses the block position held before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_data_reg <= '0;
        end else begin
            vga_data_reg <= pix_next;
        end
    end

    assign bus.vga_data   = vga_data_reg;
    assign bus.bounce_cnt = cnt_reg;

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Bench for vga_bounce_gen: four instances with different start positions share
// one stimulus stream; a behavioural model per instance is checked every cycle,
// plus directed literal checks for reset, pixel map, wall/corner bounces,
// divider timing, pause and asynchronous reset.
module tb_vga_bounce_gen;

    localparam int NI   = 4;
    localparam int TD   = 4;
    localparam int HD   = 640;
    localparam int VD   = 480;
    localparam int WS   = 40;
    localparam int BW   = 40;
    localparam int BH   = 40;
    localparam int XMIN = WS;
    localparam int XMAX = HD - WS - BW;
    localparam int YMIN = WS;
    localparam int YMAX = VD - WS - BH;
    localparam int XI [NI] = '{100, 555, 559, 560};
    localparam int YI [NI] = '{100, 100, 399, 400};

    typedef struct {
        int x;
        int y;
        bit xdec;
        bit ydec;
        int col;
        int bcnt;
        int tick;
    } ms_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] h_addr = '0;
    logic [9:0] v_addr = '0;
    logic       frame_start = 1'b0;
    logic       mode = 1'b1;
    logic       pause = 1'b0;
    logic [3:0] step_x = '0;
    logic [3:0] step_y = '0;

    logic [23:0] act_vga [NI];
    logic [15:0] act_cnt [NI];
    int          exp_x   [NI];
    int          exp_y   [NI];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ms_t mreset(input int xi, input int yi);
        ms_t s;
        s.x = xi; s.y = yi; s.xdec = 1'b0; s.ydec = 1'b0;
        s.col = 0; s.bcnt = 0; s.tick = 0;
        return s;
    endfunction

    // One axis move following the wall rules.
    function automatic void maxis(inout int p, inout bit dec, input int st,
                                  input int lo, input int hi, output bit hit);
        hit = 1'b0;
        if (st == 0) return;
        if (!dec) begin
            if (p + st >= hi) begin p = hi; dec = 1'b1; hit = 1'b1; end
            else p = p + st;
        end else begin
            if (p <= lo + st) begin p = lo; dec = 1'b0; hit = 1'b1; end
            else p = p - st;
        end
    endfunction

    function automatic ms_t mstep(input ms_t s, input bit md, input bit ps,
                                  input bit fs, input int sx, input int sy);
        ms_t n;
        bit  mv;
        bit  hh;
        bit  hv;
        int  px;
        int  py;
        bit  dx;
        bit  dy;
        n  = s;
        mv = 1'b0;
        hh = 1'b0;
        hv = 1'b0;
        if (md) begin
            n.tick = 0;
            mv = fs && !ps;
        end else if (!ps) begin
            if (n.tick == TD - 1) begin mv = 1'b1; n.tick = 0; end
            else n.tick = n.tick + 1;
        end
        if (mv) begin
            px = n.x; py = n.y; dx = n.xdec; dy = n.ydec;
            maxis(px, dx, sx, XMIN, XMAX, hh);
            maxis(py, dy, sy, YMIN, YMAX, hv);
            n.x = px; n.y = py; n.xdec = dx; n.ydec = dy;
            if (hh || hv) begin
                if (n.bcnt < 65535) n.bcnt = n.bcnt + 1;
                n.col = (n.col + 1) % 4;
            end
        end
        return n;
    endfunction

    function automatic logic [23:0] mpix(input int h, input int v, input ms_t s);
        if (h >= HD || v >= VD) return 24'h000000;
        if (h < WS || h >= HD - WS || v < WS || v >= VD - WS) return 24'h0000FF;
        if (h >= s.x && h < s.x + BW && v >= s.y && v < s.y + BH) begin
            case (s.col)
                0:       return 24'h000000;
                1:       return 24'hFF0000;
                2:       return 24'h00FF00;
                default: return 24'hFFFF00;
            endcase
        end
        return 24'hFFFFFF;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        vga_bounce_gen_if bus ();

        assign bus.h_addr      = h_addr;
        assign bus.v_addr      = v_addr;
        assign bus.frame_start = frame_start;
        assign bus.mode        = mode;
        assign bus.pause       = pause;
        assign bus.step_x      = step_x;
        assign bus.step_y      = step_y;

        vga_bounce_gen #(
            .H_DISP   (HD),
            .V_DISP   (VD),
            .W_SIDE   (WS),
            .BLK_W    (BW),
            .BLK_H    (BH),
            .X_INIT   (XI[gi]),
            .Y_INIT   (YI[gi]),
            .TICK_DIV (TD)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign act_vga[gi] = bus.vga_data;
        assign act_cnt[gi] = bus.bounce_cnt;

        ms_t         st;
        logic [23:0] exp_pix;

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                st      <= mreset(XI[gi], YI[gi]);
                exp_pix <= 24'h000000;
            end else begin
                exp_pix <= mpix(int'(h_addr), int'(v_addr), st);
                st      <= mstep(st, mode, pause, frame_start, int'(step_x), int'(step_y));
            end
        end

        assign exp_x[gi] = st.x;
        assign exp_y[gi] = st.y;

        always @(negedge clk) begin
            chk($sformatf("model inst%0d vga_data", gi), 32'(act_vga[gi]), 32'(exp_pix));
            chk($sformatf("model inst%0d bounce_cnt", gi), 32'(act_cnt[gi]), 32'(st.bcnt));
        end
    end

    task automatic probe(input int k, input int h, input int v,
                         input logic [23:0] e, input string nm);
        h_addr = 10'(h);
        v_addr = 10'(v);
        @(posedge clk);
        @(negedge clk);
        chk(nm, 32'(act_vga[k]), 32'(e));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic move_pulse();
        frame_start = 1'b1;
        @(posedge clk);
        #2 frame_start = 1'b0;
    endtask

    initial begin
        int k;
        #1 rst = 1'b0;

        // Reset state with h=v=0.
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset inst%0d vga_data", i), 32'(act_vga[i]), 32'h0);
            chk($sformatf("reset inst%0d bounce_cnt", i), 32'(act_cnt[i]), 32'h0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post-reset border pixel", 32'(act_vga[0]), 32'h0000FF);

        // Pixel map at (100,100), no moves.
        probe(0, 100, 100, 24'h000000, "map block corner");
        probe(0, 140, 100, 24'hFFFFFF, "map right of block");
        probe(0, 639, 200, 24'h0000FF, "map right border");
        probe(0, 700, 10,  24'h000000, "map blanking");

        // Right-wall clamp from x=555 with step 10.
        do_reset();
        mode = 1'b1; step_x = 4'd10; step_y = 4'd0;
        move_pulse();
        h_addr = 10'd560; v_addr = 10'd100;
        @(posedge clk);
        @(negedge clk);
        chk("wall bounce_cnt", 32'(act_cnt[1]), 32'd1);
        chk("wall block colour", 32'(act_vga[1]), 32'hFF0000);
        probe(1, 559, 100, 24'hFFFFFF, "wall left of block");
        move_pulse();
        probe(1, 550, 100, 24'hFF0000, "rebound x=550");
        probe(1, 549, 100, 24'hFFFFFF, "rebound left edge");
        chk("rebound bounce_cnt", 32'(act_cnt[1]), 32'd1);

        // Corner hit from (559,399) counts once.
        do_reset();
        mode = 1'b1; step_x = 4'd1; step_y = 4'd1;
        move_pulse();
        probe(2, 560, 400, 24'hFF0000, "corner block colour");
        chk("corner bounce_cnt", 32'(act_cnt[2]), 32'd1);
        move_pulse();
        probe(2, 559, 399, 24'hFF0000, "corner reversed");
        probe(2, 599, 439, 24'hFFFFFF, "corner old extent");

        // Divider timing, step 2 every 4 cycles, then pause.
        do_reset();
        mode = 1'b0; pause = 1'b0; step_x = 4'd2; step_y = 4'd0;
        h_addr = 10'd141; v_addr = 10'd120;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("div before first move", 32'(act_vga[0]), 32'hFFFFFF);
        @(posedge clk);
        @(negedge clk);
        chk("div after first move", 32'(act_vga[0]), 32'h000000);
        pause = 1'b1; h_addr = 10'd143;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("pause holds x", 32'(act_vga[0]), 32'hFFFFFF);
        pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pause held counter", 32'(act_vga[0]), 32'hFFFFFF);
        @(posedge clk);
        @(negedge clk);
        chk("div second move", 32'(act_vga[0]), 32'h000000);

        // Asynchronous reset between edges after five moves.
        h_addr = 10'd0; v_addr = 10'd0;
        repeat (12) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("async inst%0d vga_data", i), 32'(act_vga[i]), 32'h0);
            chk($sformatf("async inst%0d bounce_cnt", i), 32'(act_cnt[i]), 32'h0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        probe(0, 100, 100, 24'h000000, "async restart block");
        probe(0, 99, 100, 24'hFFFFFF, "async restart left");

        // Zero step on a bound: no movement, no bounce.
        do_reset();
        mode = 1'b0; step_x = 4'd0; step_y = 4'd0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("zero step no bounce", 32'(act_cnt[3]), 32'd0);
        probe(3, 560, 400, 24'h000000, "zero step block stays");

        // Randomised run checked by the per-instance models.
        mode = 1'b0; step_x = 4'd7; step_y = 4'd5;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #2;
            if (!rst) begin
                if ($urandom_range(0, 3) == 0) rst = 1'b1;
            end else if ($urandom_range(0, 699) == 0) begin
                rst = 1'b0;
            end
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            pause       = ($urandom_range(0, 9) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) begin
                step_x = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                step_y = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
            k = int'($urandom_range(0, NI - 1));
            if ($urandom_range(0, 1) == 1) begin
                h_addr = 10'(exp_x[k] + int'($urandom_range(0, 41)) - 1);
                v_addr = 10'(exp_y[k] + int'($urandom_range(0, 41)) - 1);
            end else begin
                h_addr = 10'($urandom_range(0, 799));
                v_addr = 10'($urandom_range(0, 524));
            end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
